// File: rtl/varredor_janela_10bit_if.sv
// Configuration and pixel-stream bundle of the window scan sequencer.
// The sequencer takes the slave view; the host or consumer takes the master view.
interface varredor_janela_10bit_if;
  logic        cfg_valido;
  logic        cfg_pronto;
  logic [9:0]  x_ini;
  logic [9:0]  x_fim;
  logic [9:0]  y_ini;
  logic [9:0]  y_fim;
  logic        abortar;
  logic [9:0]  px_x;
  logic [9:0]  px_y;
  logic        px_valido;
  logic        px_pronto;
  logic        px_ultimo;
  logic        ocupado;
  logic        erro_cfg;
  logic        concluido;
  logic [18:0] contagem;

  modport slave (
    input  cfg_valido, x_ini, x_fim, y_ini, y_fim, abortar, px_pronto,
    output cfg_pronto, px_x, px_y, px_valido, px_ultimo,
           ocupado, erro_cfg, concluido, contagem
  );

  modport master (
    output cfg_valido, x_ini, x_fim, y_ini, y_fim, abortar, px_pronto,
    input  cfg_pronto, px_x, px_y, px_valido, px_ultimo,
           ocupado, erro_cfg, concluido, contagem
  );
endinterface

// File: rtl/varredor_janela_10bit.sv
// Region-of-interest scan sequencer: validates a half-open window against the
// frame size, then streams every coordinate inside it in raster order.
module varredor_janela_10bit #(
  parameter int LARGURA = 640,
  parameter int ALTURA  = 480
) (
  input  logic                   clk,
  input  logic                   reset,
  varredor_janela_10bit_if.slave bus
);
  localparam logic [9:0] LARGURA_LIM = 10'(LARGURA);
  localparam logic [9:0] ALTURA_LIM  = 10'(ALTURA);

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    VERIFICA = 2'd1,
    VARRE    = 2'd2,
    FIM      = 2'd3
  } estado_t;

  estado_t     estado_reg;
  logic [9:0]  x_ini_reg;
  logic [9:0]  x_fim_reg;
  logic [9:0]  y_ini_reg;
  logic [9:0]  y_fim_reg;
  logic [9:0]  x_reg;
  logic [9:0]  y_reg;
  logic        cfg_pronto_reg;
  logic        px_valido_reg;
  logic        px_ultimo_reg;
  logic        ocupado_reg;
  logic        erro_cfg_reg;
  logic        concluido_reg;
  logic [18:0] contagem_reg;

  logic [9:0]  x_ultimo;
  logic [9:0]  y_ultimo;
  logic        cfg_invalida;
  logic        fim_linha;
  logic        ultimo_px;
  logic        primeiro_e_ultimo;
  logic        beat;
  logic [9:0]  x_next;
  logic [9:0]  y_next;
  logic        ultimo_next;

  // x_fim/y_fim are never zero while these are used (validated first).
  always_comb begin
    x_ultimo          = x_fim_reg - 10'd1;
    y_ultimo          = y_fim_reg - 10'd1;
    cfg_invalida      = (x_ini_reg >= x_fim_reg) || (y_ini_reg >= y_fim_reg) ||
                        (x_fim_reg > LARGURA_LIM) || (y_fim_reg > ALTURA_LIM);
    fim_linha         = (x_reg == x_ultimo);
    ultimo_px         = fim_linha && (y_reg == y_ultimo);
    primeiro_e_ultimo = (x_ini_reg == x_ultimo) && (y_ini_reg == y_ultimo);
    beat              = px_valido_reg && bus.px_pronto;
    x_next            = fim_linha ? x_ini_reg : x_reg + 10'd1;
    y_next            = fim_linha ? y_reg + 10'd1 : y_reg;
    ultimo_next       = (x_next == x_ultimo) && (y_next == y_ultimo);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_reg     <= OCIOSO;
      x_ini_reg      <= '0;
      x_fim_reg      <= '0;
      y_ini_reg      <= '0;
      y_fim_reg      <= '0;
      x_reg          <= '0;
      y_reg          <= '0;
      cfg_pronto_reg <= 1'b1;
      px_valido_reg  <= 1'b0;
      px_ultimo_reg  <= 1'b0;
      ocupado_reg    <= 1'b0;
      erro_cfg_reg   <= 1'b0;
      concluido_reg  <= 1'b0;
      contagem_reg   <= '0;
    end else begin
      erro_cfg_reg  <= 1'b0;
      concluido_reg <= 1'b0;
      case (estado_reg)
        OCIOSO: begin
          if (bus.cfg_valido && cfg_pronto_reg) begin
            x_ini_reg      <= bus.x_ini;
            x_fim_reg      <= bus.x_fim;
            y_ini_reg      <= bus.y_ini;
            y_fim_reg      <= bus.y_fim;
            contagem_reg   <= '0;
            cfg_pronto_reg <= 1'b0;
            ocupado_reg    <= 1'b1;
            estado_reg     <= VERIFICA;
          end
        end
        VERIFICA: begin
          if (cfg_invalida) begin
            erro_cfg_reg   <= 1'b1;
            cfg_pronto_reg <= 1'b1;
            ocupado_reg    <= 1'b0;
            estado_reg     <= OCIOSO;
          end else begin
            x_reg         <= x_ini_reg;
            y_reg         <= y_ini_reg;
            px_valido_reg <= 1'b1;
            px_ultimo_reg <= primeiro_e_ultimo;
            estado_reg    <= VARRE;
          end
        end
        VARRE: begin
          // Abort wins over a coinciding beat, which is then not counted.
          if (bus.abortar) begin
            px_valido_reg  <= 1'b0;
            px_ultimo_reg  <= 1'b0;
            cfg_pronto_reg <= 1'b1;
            ocupado_reg    <= 1'b0;
            estado_reg     <= OCIOSO;
          end else if (beat) begin
            contagem_reg <= contagem_reg + 19'd1;
            if (ultimo_px) begin
              px_valido_reg <= 1'b0;
              px_ultimo_reg <= 1'b0;
              concluido_reg <= 1'b1;
              estado_reg    <= FIM;
            end else begin
              x_reg         <= x_next;
              y_reg         <= y_next;
              px_ultimo_reg <= ultimo_next;
            end
          end
        end
        FIM: begin
          cfg_pronto_reg <= 1'b1;
          ocupado_reg    <= 1'b0;
          estado_reg     <= OCIOSO;
        end
        default: begin
          estado_reg <= OCIOSO;
        end
      endcase
    end
  end

  assign bus.cfg_pronto = cfg_pronto_reg;
  assign bus.px_x       = x_reg;
  assign bus.px_y       = y_reg;
  assign bus.px_valido  = px_valido_reg;
  assign bus.px_ultimo  = px_ultimo_reg;
  assign bus.ocupado    = ocupado_reg;
  assign bus.erro_cfg   = erro_cfg_reg;
  assign bus.concluido  = concluido_reg;
  assign bus.contagem   = contagem_reg;
endmodule

// File: tb/tb_varredor_janela_10bit.sv
// Bench for varredor_janela_10bit: queue-based window model checked every cycle,
// directed windows with literal expectations, then randomized windows.
module tb_varredor_janela_10bit;
  localparam int P_IDLE = 0;
  localparam int P_CHECK = 1;
  localparam int P_SCAN = 2;
  localparam int P_DONE = 3;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
  } coord_t;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       u;
  } beat_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  varredor_janela_10bit_if bus ();

  varredor_janela_10bit #(.LARGURA(640), .ALTURA(480)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Stimulus sources, merged onto the bus.
  logic       cfg_main = 1'b0;
  logic [9:0] d_xi = '0, d_xf = '0, d_yi = '0, d_yf = '0;
  logic       cfg_noise = 1'b0;
  logic [9:0] n_xi = '0, n_xf = '0, n_yi = '0, n_yf = '0;
  logic       abort_main = 1'b0;
  logic       abort_rand = 1'b0;
  logic       pronto_b = 1'b1;
  int         pr_mode = 0;
  bit         abort_en = 1'b0;
  bit         noise_en = 1'b0;

  assign bus.cfg_valido = cfg_main | cfg_noise;
  assign bus.x_ini      = cfg_noise ? n_xi : d_xi;
  assign bus.x_fim      = cfg_noise ? n_xf : d_xf;
  assign bus.y_ini      = cfg_noise ? n_yi : d_yi;
  assign bus.y_fim      = cfg_noise ? n_yf : d_yf;
  assign bus.abortar    = abort_main | abort_rand;
  assign bus.px_pronto  = pronto_b;

  int n_checks = 0;
  int n_err = 0;
  int n_concl = 0;
  int n_erro = 0;
  beat_t blog[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: window contents as a queue of coordinates.
  int         m_phase = P_IDLE;
  bit         m_ready = 1'b0;
  bit         m_coord_known = 1'b0;
  int         m_cnt = 0;
  bit         m_err = 1'b0;
  bit         m_done = 1'b0;
  int         mxi, mxf, myi, myf;
  coord_t     m_q[$];

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        m_ready = 1'b1;
        m_phase = P_IDLE;
        m_cnt = 0;
        m_q.delete();
        m_err = 1'b0;
        m_done = 1'b0;
        m_coord_known = 1'b1;
      end else if (m_ready) begin
        m_err = 1'b0;
        m_done = 1'b0;
        case (m_phase)
          P_IDLE: if (bus.cfg_valido) begin
            mxi = int'(bus.x_ini); mxf = int'(bus.x_fim);
            myi = int'(bus.y_ini); myf = int'(bus.y_fim);
            m_cnt = 0;
            m_phase = P_CHECK;
          end
          P_CHECK: begin
            if (!(mxi < mxf && myi < myf && mxf <= 640 && myf <= 480)) begin
              m_err = 1'b1;
              m_phase = P_IDLE;
            end else begin
              for (int yy = myi; yy < myf; yy++)
                for (int xx = mxi; xx < mxf; xx++)
                  m_q.push_back('{x: 10'(xx), y: 10'(yy)});
              m_coord_known = 1'b0;
              m_phase = P_SCAN;
            end
          end
          P_SCAN: begin
            if (bus.abortar) begin
              m_q.delete();
              m_phase = P_IDLE;
            end else if (bus.px_pronto) begin
              m_cnt++;
              void'(m_q.pop_front());
              if (m_q.size() == 0) begin
                m_phase = P_DONE;
                m_done = 1'b1;
              end
            end
          end
          default: m_phase = P_IDLE;
        endcase
      end
    end
  end

  // Per-cycle comparison against the model, plus beat/pulse logging.
  initial begin
    forever begin
      @(negedge clk);
      if (m_ready) begin
        check("cfg_pronto", 32'(bus.cfg_pronto), 32'(m_phase == P_IDLE));
        check("ocupado", 32'(bus.ocupado), 32'(m_phase != P_IDLE));
        check("px_valido", 32'(bus.px_valido), 32'(m_phase == P_SCAN));
        check("erro_cfg", 32'(bus.erro_cfg), 32'(m_err));
        check("concluido", 32'(bus.concluido), 32'(m_done));
        check("contagem", 32'(bus.contagem), 32'(m_cnt));
        if (m_phase == P_SCAN && m_q.size() > 0) begin
          check("px_x", 32'(bus.px_x), 32'(m_q[0].x));
          check("px_y", 32'(bus.px_y), 32'(m_q[0].y));
          check("px_ultimo", 32'(bus.px_ultimo), 32'(m_q.size() == 1));
        end else begin
          check("px_ultimo_idle", 32'(bus.px_ultimo), 32'd0);
          if (m_coord_known) begin
            check("px_x_rst", 32'(bus.px_x), 32'd0);
            check("px_y_rst", 32'(bus.px_y), 32'd0);
          end
        end
      end
      if (bus.px_valido && bus.px_pronto && !bus.abortar && !reset)
        blog.push_back('{x: bus.px_x, y: bus.px_y, u: bus.px_ultimo});
      if (bus.concluido) n_concl++;
      if (bus.erro_cfg) n_erro++;
    end
  end

  // Consumer: ready pattern and random aborts.
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk);
      #1;
      case (pr_mode)
        0: pronto_b = 1'b1;
        1: begin
          pronto_b = (ph == 0);
          ph = (ph + 1) % 3;
        end
        default: pronto_b = ($urandom_range(0, 9) < 7);
      endcase
      abort_rand = abort_en && ($urandom_range(0, 39) == 0);
    end
  end

  // Configuration noise while busy; must be ignored.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cfg_noise = noise_en && bus.ocupado && ($urandom_range(0, 3) == 0);
      n_xi = 10'($urandom_range(0, 1023));
      n_xf = 10'($urandom_range(0, 1023));
      n_yi = 10'($urandom_range(0, 1023));
      n_yf = 10'($urandom_range(0, 1023));
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_cfg(input logic [9:0] xi, input logic [9:0] xf,
                          input logic [9:0] yi, input logic [9:0] yf);
    for (int i = 0; i < 50 && !bus.cfg_pronto; i++) begin
      @(posedge clk);
      #1;
    end
    check("cfg_ready_wait", 32'(bus.cfg_pronto), 32'd1);
    cfg_main = 1'b1;
    d_xi = xi; d_xf = xf; d_yi = yi; d_yf = yf;
    @(posedge clk);
    #1;
    cfg_main = 1'b0;
    d_xi = 10'($urandom_range(0, 1023));
    d_xf = 10'($urandom_range(0, 1023));
    d_yi = 10'($urandom_range(0, 1023));
    d_yf = 10'($urandom_range(0, 1023));
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && !bus.cfg_pronto; i++) begin
      @(posedge clk);
      #1;
    end
    check("idle_timeout", 32'(bus.cfg_pronto), 32'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_small_window(input string tag);
    int ex[6];
    int ey[6];
    ex = '{2, 3, 4, 2, 3, 4};
    ey = '{3, 3, 3, 4, 4, 4};
    check({tag, "_len"}, 32'(blog.size()), 32'd6);
    if (blog.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        check({tag, "_x"}, 32'(blog[i].x), 32'(ex[i]));
        check({tag, "_y"}, 32'(blog[i].y), 32'(ey[i]));
        check({tag, "_ult"}, 32'(blog[i].u), 32'(i == 5));
      end
    end
  endtask

  initial begin
    int c0;
    int e0;
    logic [9:0] xi, xf, yi, yf;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_cfg_pronto", 32'(bus.cfg_pronto), 32'd1);
    check("rst_px_valido", 32'(bus.px_valido), 32'd0);
    check("rst_contagem", 32'(bus.contagem), 32'd0);

    // Small window, always ready.
    pr_mode = 0;
    blog.delete();
    c0 = n_concl;
    send_cfg(10'd2, 10'd5, 10'd3, 10'd5);
    wait_idle(200);
    check_small_window("win_ready");
    check("win_ready_cnt", 32'(bus.contagem), 32'd6);
    check("win_ready_concl", 32'(n_concl - c0), 32'd1);

    // Same window with 1,0,0 ready pattern.
    pr_mode = 1;
    blog.delete();
    c0 = n_concl;
    send_cfg(10'd2, 10'd5, 10'd3, 10'd5);
    wait_idle(200);
    check_small_window("win_stall");
    check("win_stall_cnt", 32'(bus.contagem), 32'd6);
    check("win_stall_concl", 32'(n_concl - c0), 32'd1);

    // Rejections.
    pr_mode = 0;
    for (int k = 0; k < 3; k++) begin
      blog.delete();
      e0 = n_erro;
      case (k)
        0: send_cfg(10'd5, 10'd5, 10'd0, 10'd2);
        1: send_cfg(10'd0, 10'd4, 10'd7, 10'd3);
        default: send_cfg(10'd600, 10'd641, 10'd0, 10'd2);
      endcase
      wait_idle(50);
      check("reject_pulse", 32'(n_erro - e0), 32'd1);
      check("reject_beats", 32'(blog.size()), 32'd0);
    end

    // Full-width strip touching both frame limits.
    blog.delete();
    send_cfg(10'd0, 10'd640, 10'd470, 10'd480);
    wait_idle(8000);
    check("strip_len", 32'(blog.size()), 32'd6400);
    check("strip_cnt", 32'(bus.contagem), 32'd6400);
    if (blog.size() == 6400) begin
      check("strip_wrap_a", {12'd0, blog[639]}, {12'd0, 10'd639, 10'd470, 1'b0});
      check("strip_wrap_b", {12'd0, blog[640]}, {12'd0, 10'd0, 10'd471, 1'b0});
      check("strip_last", {12'd0, blog[6399]}, {12'd0, 10'd639, 10'd479, 1'b1});
    end

    // Abort on the 4th beat.
    c0 = n_concl;
    send_cfg(10'd0, 10'd10, 10'd0, 10'd2);
    for (int i = 0; i < 20 && !(bus.px_valido && bus.px_x == 10'd3); i++) begin
      @(posedge clk);
      #1;
    end
    check("abort_reach", 32'(bus.px_x), 32'd3);
    abort_main = 1'b1;
    @(posedge clk);
    #1;
    abort_main = 1'b0;
    check("abort_valido", 32'(bus.px_valido), 32'd0);
    check("abort_pronto", 32'(bus.cfg_pronto), 32'd1);
    check("abort_cnt", 32'(bus.contagem), 32'd3);
    send_cfg(10'd4, 10'd6, 10'd1, 10'd2);
    wait_idle(50);
    check("abort_concl", 32'(n_concl - c0), 32'd1);
    check("after_abort_cnt", 32'(bus.contagem), 32'd2);

    // Reset in the middle of a scan.
    send_cfg(10'd100, 10'd200, 10'd10, 10'd20);
    repeat (30) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("midrst_valido", 32'(bus.px_valido), 32'd0);
    check("midrst_cnt", 32'(bus.contagem), 32'd0);
    check("midrst_ocupado", 32'(bus.ocupado), 32'd0);
    check("midrst_px_x", 32'(bus.px_x), 32'd0);
    blog.delete();
    send_cfg(10'd0, 10'd1, 10'd0, 10'd1);
    wait_idle(50);
    check("single_len", 32'(blog.size()), 32'd1);
    if (blog.size() == 1)
      check("single_beat", {12'd0, blog[0]}, {12'd0, 10'd0, 10'd0, 1'b1});

    // Randomized windows with stalls, aborts and busy-time config noise.
    pr_mode = 2;
    abort_en = 1'b1;
    noise_en = 1'b1;
    for (int t = 0; t < 40; t++) begin
      int r;
      r = $urandom_range(0, 8);
      if (r < 6) begin
        xi = 10'($urandom_range(0, 630)); xf = xi + 10'($urandom_range(1, 8));
        yi = 10'($urandom_range(0, 470)); yf = yi + 10'($urandom_range(1, 4));
      end else if (r == 6) begin
        xf = 10'($urandom_range(638, 642)); xi = xf - 10'($urandom_range(0, 3));
        yi = 10'($urandom_range(0, 100)); yf = yi + 10'($urandom_range(1, 3));
      end else if (r == 7) begin
        yf = 10'($urandom_range(478, 482)); yi = yf - 10'($urandom_range(0, 2));
        xi = 10'($urandom_range(0, 100)); xf = xi + 10'($urandom_range(1, 5));
      end else begin
        xi = 10'($urandom_range(10, 20)); xf = 10'($urandom_range(0, 10));
        yi = 10'($urandom_range(0, 10)); yf = 10'($urandom_range(0, 12));
      end
      send_cfg(xi, xf, yi, yf);
      wait_idle(2000);
    end
    abort_en = 1'b0;
    noise_en = 1'b0;
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
